// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch/decode sequencer.
//   - state_e      : sequencer state encoding
//   - OP_*         : instruction opcodes (anything else is illegal)
//   - IR_*         : bit positions of the instruction register fields
//   - SEL_*        : bit indices inside the one-hot exec_sel bus
//   - exec_sel_of  : opcode -> one-hot execute-unit select
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOVI = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int IR_OPC_MSB = 15;
    localparam int IR_OPC_LSB = 12;
    localparam int IR_P1_MSB  = 11;
    localparam int IR_P1_LSB  = 6;
    localparam int IR_P2_MSB  = 5;
    localparam int IR_P2_LSB  = 0;

    localparam int SEL_MOVI = 0;
    localparam int SEL_MOV  = 1;
    localparam int SEL_ADD  = 2;
    localparam int SEL_SUB  = 3;

    // One-hot select for the execute FSM that owns an opcode; zero for
    // opcodes that are handled inside the sequencer or are illegal.
    function automatic logic [3:0] exec_sel_of(input logic [3:0] op);
        logic [3:0] sel;
        sel = 4'b0000;
        case (op)
            OP_MOVI: sel[SEL_MOVI] = 1'b1;
            OP_MOV:  sel[SEL_MOV]  = 1'b1;
            OP_ADD:  sel[SEL_ADD]  = 1'b1;
            OP_SUB:  sel[SEL_SUB]  = 1'b1;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/fetch_wdog.sv
// fetch_wdog: execute-phase watchdog counter.
//   clk     in  system clock
//   rst     in  asynchronous active-low reset
//   clr     in  synchronous clear (wins over en)
//   en      in  count one cycle
//   expired out counter has reached TIMEOUT-1 (decoded from the register)
// The counter saturates at TIMEOUT-1 so expired stays up until cleared.
module fetch_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = (cnt_q == LAST);

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch/decode sequencer feeding the execute FSMs.
//   clk, rst          clock / asynchronous active-low reset
//   run               level enable for starting new fetches
//   mem_rd, mem_addr  program memory read request (held until mem_ack) and address (= pc)
//   mem_rdata, mem_ack instruction word and its one-cycle acknowledge
//   donefetch         one-cycle pulse in DECODE that clears the execute FSMs
//   start, exec_sel   held through EXEC; one-hot {sub,add,mov,movi}
//   exec_done         OR of the execute FSM done outputs
//   parameter1/2, opcode  IR[11:6], IR[5:0], IR[15:12]
//   pc                current program counter
//   halted, err_illegal, err_timeout  sticky status flags
// Every output is decoded from registered state, so nothing combinational
// runs from an input to an output.
module fetch_decode
    import fetch_pkg::*;
#(
    parameter int              PC_W    = 8,
    parameter logic [PC_W-1:0] RST_PC  = {PC_W{1'b0}},
    parameter int              TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            mem_rd,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ack,
    output logic            donefetch,
    output logic            start,
    output logic [3:0]      exec_sel,
    input  logic            exec_done,
    output logic [5:0]      parameter1,
    output logic [5:0]      parameter2,
    output logic [3:0]      opcode,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            err_illegal,
    output logic            err_timeout
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            halted_q, halted_d;
    logic            err_illegal_q, err_illegal_d;
    logic            err_timeout_q, err_timeout_d;

    logic [3:0]       opc_s;
    logic [PC_W+11:0] jmp_ext_s;
    logic             wdog_clr_s;
    logic             wdog_en_s;
    logic             wdog_expired_s;

    assign opc_s = ir_q[IR_OPC_MSB:IR_OPC_LSB];

    // JMP target is the 12-bit {p1,p2} field; zero-extending to at least
    // PC_W bits and taking the low PC_W covers both narrower and wider pcs.
    assign jmp_ext_s = {{PC_W{1'b0}}, ir_q[IR_P1_MSB:IR_P2_LSB]};

    // The watchdog only counts inside EXEC and restarts on every completion.
    assign wdog_en_s  = (state_q == ST_EXEC);
    assign wdog_clr_s = (state_q != ST_EXEC) || exec_done;

    fetch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr_s),
        .en      (wdog_en_s),
        .expired (wdog_expired_s)
    );

    // Sequencer next-state, pc, IR and sticky flag logic.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        halted_d      = halted_q;
        err_illegal_d = err_illegal_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // run is not looked at: an issued read always completes.
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opc_s)
                    OP_MOVI, OP_MOV, OP_ADD, OP_SUB: begin
                        state_d = ST_EXEC;
                    end
                    OP_NOP: begin
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end
                    OP_JMP: begin
                        pc_d    = jmp_ext_s[PC_W-1:0];
                        state_d = run ? ST_FETCH : ST_IDLE;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    default: begin
                        halted_d      = 1'b1;
                        err_illegal_d = 1'b1;
                        state_d       = ST_HALT;
                    end
                endcase
            end
            ST_EXEC: begin
                // Completion takes priority over a watchdog expiring in the
                // same cycle.
                if (exec_done) begin
                    state_d = run ? ST_FETCH : ST_IDLE;
                end else if (wdog_expired_s) begin
                    halted_d      = 1'b1;
                    err_timeout_d = 1'b1;
                    state_d       = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RST_PC;
            ir_q          <= 16'h0000;
            halted_q      <= 1'b0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            halted_q      <= halted_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign mem_rd      = (state_q == ST_FETCH);
    assign mem_addr    = pc_q;
    assign donefetch   = (state_q == ST_DECODE);
    assign start       = (state_q == ST_EXEC);
    assign exec_sel    = (state_q == ST_EXEC) ? exec_sel_of(opc_s) : 4'b0000;
    assign opcode      = opc_s;
    assign parameter1  = ir_q[IR_P1_MSB:IR_P1_LSB];
    assign parameter2  = ir_q[IR_P2_MSB:IR_P2_LSB];
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Testbench for fetch_decode: directed scenarios plus randomized programs
// checked against an instruction-level interpreter through a scoreboard.
module tb_fetch_decode;

    logic        clk;
    logic        rst;
    logic        run;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        donefetch;
    logic        start;
    logic [3:0]  exec_sel;
    logic        exec_done;
    logic [5:0]  parameter1;
    logic [5:0]  parameter2;
    logic [3:0]  opcode;
    logic [7:0]  pc;
    logic        halted;
    logic        err_illegal;
    logic        err_timeout;

    fetch_decode #(
        .PC_W    (8),
        .RST_PC  (8'h00),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .donefetch   (donefetch),
        .start       (start),
        .exec_sel    (exec_sel),
        .exec_done   (exec_done),
        .parameter1  (parameter1),
        .parameter2  (parameter2),
        .opcode      (opcode),
        .pc          (pc),
        .halted      (halted),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] mem [256];
    int  ack_delay = 0;   // <0: random 0..3 extra FETCH cycles
    int  exec_lat  = 0;   // <0: random 0..5 extra EXEC cycles
    bit  exec_auto = 1'b1;
    bit  stray_en  = 1'b0;
    bit  mon_en    = 1'b0;
    bit  model_halt = 1'b0;
    bit  exp_ill    = 1'b0;

    logic [7:0]  fetch_q [$];
    logic [23:0] exec_q  [$];   // {exec_sel, p1, p2, pc after fetch}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Program memory responder: acks after ack_delay extra cycles.
    initial begin
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom());
            if (!mem_rd) begin
                busy = 1'b0;
                if (stray_en && $urandom_range(0, 7) == 0) mem_ack = 1'b1;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
                end
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Execute-unit responder: pulses exec_done after exec_lat extra cycles.
    initial begin
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        exec_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            exec_done = 1'b0;
            if (!start) begin
                busy = 1'b0;
                if (stray_en && $urandom_range(0, 7) == 0) exec_done = 1'b1;
            end else if (exec_auto) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = (exec_lat < 0) ? int'($urandom_range(0, 5)) : exec_lat;
                end
                if (cnt == 0) exec_done = 1'b1;
                else cnt--;
            end
        end
    end

    // Scoreboard monitor: compares each fetch and each EXEC entry in order.
    initial begin
        logic        start_prev;
        logic [7:0]  ea;
        logic [23:0] ex;
        start_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mem_rd && mem_ack) begin
                    if (fetch_q.size() > 0) begin
                        ea = fetch_q.pop_front();
                        check("sb_fetch_addr", mem_addr, ea);
                    end else if (model_halt) begin
                        check("sb_fetch_after_halt", mem_rd, 1'b0);
                    end
                end
                if (start && !start_prev) begin
                    if (exec_q.size() > 0) begin
                        ex = exec_q.pop_front();
                        check("sb_exec", {exec_sel, parameter1, parameter2, pc}, ex);
                    end else if (model_halt) begin
                        check("sb_exec_after_halt", start, 1'b0);
                    end
                end
            end
            start_prev = start;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("reset_state", {mem_rd, donefetch, start, exec_sel, halted, err_illegal,
                              err_timeout, pc, opcode, parameter1, parameter2}, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // Counts cycles with any sequencer activity; a halted/idle core shows none.
    task automatic check_quiet(input string name, input int ncyc);
        int act;
        act = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (mem_rd || start || donefetch) act++;
        end
        check(name, act, 0);
    endtask

    task automatic wait_for_start(input int budget);
        int n;
        n = 0;
        while (!start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_start", start, 1'b1);
    endtask

    task automatic count_start(output int cnt);
        cnt = 0;
        while (start && cnt < 60) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic gen_program(input bit allow_halt);
        logic [31:0] r;
        logic [3:0]  op;
        for (int i = 0; i < 256; i++) begin
            r  = $urandom();
            op = 4'($urandom_range(0, 5));
            if (allow_halt && $urandom_range(0, 59) == 0)
                op = ($urandom_range(0, 1) == 1) ? 4'hF : 4'(6 + $urandom_range(0, 8));
            mem[i] = {op, r[11:0]};
        end
    endtask

    // Instruction-level interpreter producing the expected fetch/exec trace.
    task automatic build_model(input int nstep);
        logic [7:0]  pc_m;
        logic [7:0]  nxt;
        logic [15:0] w;
        logic [3:0]  op;
        logic [3:0]  sel;
        fetch_q.delete();
        exec_q.delete();
        model_halt = 1'b0;
        exp_ill = 1'b0;
        pc_m = 8'h00;
        for (int n = 0; n < nstep && !model_halt; n++) begin
            w  = mem[pc_m];
            op = w[15:12];
            fetch_q.push_back(pc_m);
            nxt = pc_m + 8'd1;
            if (op >= 4'd1 && op <= 4'd4) begin
                sel = 4'b0001 << (op - 4'd1);
                exec_q.push_back({sel, w[11:6], w[5:0], nxt});
            end else if (op == 4'd5) begin
                nxt = w[7:0];
            end else if (op != 4'd0) begin
                model_halt = 1'b1;
                exp_ill = (op != 4'hF);
            end
            pc_m = nxt;
        end
    endtask

    task automatic random_round(input bit allow_halt);
        int n;
        gen_program(allow_halt);
        build_model(150);
        ack_delay = -1;
        exec_lat  = -1;
        exec_auto = 1'b1;
        stray_en  = 1'b1;
        run = 1'b1;
        do_reset();
        mon_en = 1'b1;
        n = 0;
        while ((fetch_q.size() != 0 || exec_q.size() != 0) && n < 20000) begin
            @(posedge clk);
            #1 run = ($urandom_range(0, 3) != 0);
            n++;
        end
        check("rnd_drained", fetch_q.size() + exec_q.size(), 0);
        run = 1'b0;
        repeat (60) @(negedge clk);
        mon_en = 1'b0;
        stray_en = 1'b0;
        check("rnd_flags", {halted, err_illegal, err_timeout}, {model_halt, exp_ill, 1'b0});
    endtask

    initial begin
        int n;
        int cnt;
        int bad;
        bit saw_start;
        rst = 1'b0;
        run = 1'b0;

        // MOVI with ack in the third FETCH cycle, then a 3-cycle EXEC.
        clear_mem();
        mem[0] = 16'h11C5;
        ack_delay = 2;
        exec_lat = 2;
        run = 1'b1;
        do_reset();
        n = 0;
        while (!mem_rd && n < 10) begin @(negedge clk); n++; end
        cnt = 0;
        bad = 0;
        while (mem_rd && cnt < 20) begin
            if (mem_addr !== 8'h00) bad = 1;
            cnt++;
            @(negedge clk);
        end
        check("t1_fetch_cycles", cnt, 3);
        check("t1_fetch_addr_bad", bad, 0);
        check("t1_decode", {donefetch, start}, 2'b10);
        @(negedge clk);
        check("t1_exec", {start, donefetch, exec_sel, parameter1, parameter2, opcode, pc},
              {1'b1, 1'b0, 4'b0001, 6'h07, 6'h05, 4'h1, 8'h01});
        count_start(cnt);
        check("t1_exec_cycles", cnt, 3);
        check("t1_next_fetch", {mem_rd, mem_addr, pc}, {1'b1, 8'h01, 8'h01});

        // JMP: no start, pc reloaded, then HALT at the target.
        clear_mem();
        mem[0] = 16'h500A;
        mem[10] = 16'hF000;
        ack_delay = 0;
        do_reset();
        n = 0;
        while (!mem_rd && n < 10) begin @(negedge clk); n++; end
        check("t2_first_addr", {mem_rd, mem_addr}, {1'b1, 8'h00});
        @(negedge clk);
        check("t2_decode", {donefetch, start}, 2'b10);
        @(negedge clk);
        check("t2_jump", {mem_rd, mem_addr, pc}, {1'b1, 8'h0A, 8'h0A});
        saw_start = 1'b0;
        n = 0;
        while (!halted && n < 20) begin
            if (start) saw_start = 1'b1;
            @(negedge clk);
            n++;
        end
        check("t2_halt", {halted, err_illegal, err_timeout, saw_start}, 4'b1000);
        check_quiet("t2_quiet_after_halt", 10);

        // Illegal opcode.
        clear_mem();
        mem[0] = 16'h7000;
        do_reset();
        n = 0;
        while (!halted && n < 20) begin @(negedge clk); n++; end
        check("t3_illegal", {halted, err_illegal, err_timeout}, 3'b110);
        check_quiet("t3_quiet_after_illegal", 20);

        // ADD never completes: watchdog after 16 EXEC cycles.
        clear_mem();
        mem[0] = 16'h3000;
        exec_auto = 1'b0;
        do_reset();
        wait_for_start(20);
        check("t4_sel", exec_sel, 4'b0100);
        count_start(cnt);
        check("t4_timeout_cycles", cnt, 16);
        check("t4_timeout_flags", {halted, err_timeout, err_illegal, mem_rd}, 4'b1100);
        check_quiet("t4_quiet_after_timeout", 10);

        // Done on the 16th EXEC cycle wins over expiry.
        exec_auto = 1'b1;
        exec_lat = 15;
        do_reset();
        wait_for_start(20);
        count_start(cnt);
        check("t4b_exec_cycles", cnt, 16);
        check("t4b_no_error", {halted, err_timeout, mem_rd, mem_addr}, {1'b0, 1'b0, 1'b1, 8'h01});

        // pc wrap at 8'hFF, then run dropped in the middle of a fetch.
        clear_mem();
        mem[0] = 16'h50FF;
        ack_delay = 1;
        do_reset();
        n = 0;
        while (!(mem_rd && mem_addr == 8'hFF) && n < 30) begin @(negedge clk); n++; end
        check("t5_reach_ff", {mem_rd, mem_addr}, {1'b1, 8'hFF});
        n = 0;
        while (!donefetch && n < 10) begin @(negedge clk); n++; end
        check("t5_wrap_pc", {donefetch, pc}, {1'b1, 8'h00});
        @(negedge clk);
        check("t5_wrap_fetch", {mem_rd, mem_addr}, {1'b1, 8'h00});
        ack_delay = 3;
        n = 0;
        while (mem_rd && n < 10) begin @(negedge clk); n++; end
        while (!mem_rd && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 run = 1'b0;
        n = 0;
        while (!donefetch && n < 10) begin @(negedge clk); n++; end
        check("t5_fetch_completes", donefetch, 1'b1);
        @(negedge clk);
        check_quiet("t5_idle_after_run_drop", 10);

        // Asynchronous reset in the middle of EXEC.
        clear_mem();
        mem[0] = 16'h2041;
        exec_auto = 1'b0;
        run = 1'b1;
        do_reset();
        wait_for_start(20);
        check("t6_exec_state", {exec_sel, parameter1, parameter2, pc}, {4'b0010, 6'h01, 6'h01, 8'h01});
        repeat (3) @(negedge clk);
        run = 1'b0;
        do_reset();
        exec_auto = 1'b1;

        // Randomized programs against the interpreter.
        random_round(1'b0);
        random_round(1'b1);
        random_round(1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Instruction fetch/decode sequencer, directly upstream of the per-instruction execute FSMs (movi, mov, add, sub).
- Reads one 16-bit instruction word per step from program memory over a req/ack handshake and latches it in an IR.
- Decodes the word, pulses donefetch to clear the execute FSMs, then holds start plus a one-hot select until the selected FSM reports done.
- Handles NOP, JMP and HALT internally, and runs a watchdog on execute.

Parameters:
- PC_W, 8, program counter / memory address width.
- RST_PC, 0, PC value after reset.
- TIMEOUT, 16, maximum EXEC cycles before watchdog error (at least 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = sequencer may fetch.
- mem_rd  out  1  read request, held until mem_ack.
- mem_addr  out  PC_W  read address (= pc).
- mem_rdata  in  16  instruction word, valid with mem_ack.
- mem_ack  in  1  one-cycle read acknowledge.
- donefetch  out  1  one-cycle pulse in DECODE; clears execute FSMs.
- start  out  1  held high through EXEC.
- exec_sel  out  4  one-hot {sub,add,mov,movi}, valid while start=1.
- exec_done  in  1  OR of execute FSM done outputs.
- parameter1  out  6  IR[11:6].
- parameter2  out  6  IR[5:0].
- opcode  out  4  IR[15:12].
- pc  out  PC_W  current program counter.
- halted  out  1  sticky; HALT state reached.
- err_illegal  out  1  sticky; undefined opcode decoded.
- err_timeout  out  1  sticky; watchdog expired.

Behaviour:
- Reset (rst=0, async): state IDLE, pc=RST_PC, IR=0, wdog=0. All strobes and flags 0. mem_rd drops immediately.
- States: IDLE, FETCH, DECODE, EXEC, HALT. All outputs are decoded from registered state/IR; no input-to-output combinational path.
- IDLE: run=1 -> FETCH next cycle. Otherwise stay.
- FETCH: mem_rd=1, mem_addr=pc.
  - mem_ack=1 (ack may arrive in the first FETCH cycle): IR<=mem_rdata, pc<=pc+1 mod 2^PC_W, go to DECODE.
  - A fetch in progress always completes, even if run drops.
  - mem_ack outside FETCH is ignored.
- DECODE (exactly 1 cycle): donefetch=1. Next state by opcode:
  - MOVI/MOV/ADD/SUB -> EXEC.
  - NOP -> FETCH if run=1, else IDLE.
  - JMP -> pc<={parameter1,parameter2}[PC_W-1:0] (truncated or zero-extended), then FETCH/IDLE as for NOP.
  - HALT -> HALT, halted<=1.
  - Undefined opcode -> HALT, err_illegal<=1, halted<=1.
- EXEC:
  - start=1. exec_sel is one-hot per opcode and stable. wdog increments each cycle.
  - exec_done=1 -> start drops next cycle, wdog<=0, go to FETCH if run=1, else IDLE.
  - wdog reaches TIMEOUT-1 with exec_done=0 -> HALT, err_timeout<=1, halted<=1.
  - exec_done and expiry in the same cycle: done wins, no error.
- HALT: absorbing; only rst leaves it. mem_rd=0, start=0.
- IR (and therefore opcode/parameter1/parameter2) changes only on mem_ack in FETCH. It is stable from DECODE until the next ack.
- exec_done seen outside EXEC: ignored.
- Minimum instruction cost, ack in first FETCH cycle: FETCH 1 + DECODE 1 + EXEC (>=1) cycles.

Decomposition:
- Package fetch_pkg:
  - State enum.
  - Opcode constants: NOP=4'h0, MOVI=4'h1, MOV=4'h2, ADD=4'h3, SUB=4'h4, JMP=4'h5, HALT=4'hF; all others illegal.
  - IR field bit positions.
  - exec_sel bit indices.
- One sub-module, fetch_wdog: the EXEC cycle counter with clear/enable inputs and an expired output, parameterised by TIMEOUT.

Test Plan:
- Reset, run=1, mem returns 16'h1 1C5 (opcode MOVI, p1=6'h07, p2=6'h05) with ack after 3 cycles -> mem_rd high 3 cycles with mem_addr=0. Then DECODE: donefetch for 1 cycle. Then EXEC: start=1, exec_sel=4'b0001, parameter1=7, parameter2=5; exec_done pulse -> pc=1, new FETCH.
- Word 16'h5 00A (JMP) at pc=0 -> no start pulse, pc=8'h0A, next mem_addr=8'h0A.
- Word 16'h7 000 (illegal) -> err_illegal=1, halted=1, no further mem_rd until rst.
- ADD issued, exec_done never asserted -> start high exactly 16 cycles, then err_timeout=1, halted=1. Repeat with done on the 16th EXEC cycle -> no error.
- pc=8'hFF, NOP fetched -> pc wraps to 8'h00. Drop run during FETCH -> fetch completes, then IDLE, mem_rd=0.
- Assert rst during EXEC with start=1 -> start, mem_rd and donefetch 0 asynchronously; pc=RST_PC; flags cleared.
